// File: rtl/demux_stream_router_pkg.sv
// Purpose: shared constants for the 1:4 stream demux (and its 4:1 mux sibling).
// Contents: output count, select width, select codes CH0..CH3, select decode helper.
// Select codes {b,a}: 00->ch0, 01->ch1, 10->ch2, 11->ch3.
package demux_stream_router_pkg;

  localparam int NOUT = 4;
  localparam int SELW = 2;

  localparam logic [SELW-1:0] CH0 = 2'b00;
  localparam logic [SELW-1:0] CH1 = 2'b01;
  localparam logic [SELW-1:0] CH2 = 2'b10;
  localparam logic [SELW-1:0] CH3 = 2'b11;

  // One-hot decode of a select code; every code is legal.
  function automatic logic [NOUT-1:0] sel_onehot(input logic [SELW-1:0] sel);
    logic [NOUT-1:0] hot;
    hot = '0;
    case (sel)
      CH0: hot = 4'b0001;
      CH1: hot = 4'b0010;
      CH2: hot = 4'b0100;
      CH3: hot = 4'b1000;
      default: hot = '0;
    endcase
    return hot;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// Purpose: one-entry holding slot for one demux output, plus saturating delivered-beat counter.
// Latency: a beat loaded in cycle N is on out_valid/out_data in cycle N+1.
// Backpressure: holds its beat stable until out_ready; can_load = !full | out_ready (pass-through when draining).
// Ports: clk, rst (sync, active-high), load/load_data (write strobe and payload),
//        out_ready/out_valid/out_data (consumer handshake), out_cnt (beats delivered), can_load.
module demux_out_slot
  import demux_stream_router_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DW-1:0]   load_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [CNTW-1:0] out_cnt,
  output logic            can_load
);

  logic            full;
  logic [DW-1:0]   data;
  logic [CNTW-1:0] cnt;
  logic            deliver;

  assign deliver   = full & out_ready;
  assign can_load  = ~full | out_ready;
  assign out_valid = full;
  assign out_data  = data;
  assign out_cnt   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
      cnt  <= '0;
    end else begin
      // A load while draining keeps the slot full with the new beat (no bubble).
      if (load) begin
        full <= 1'b1;
        data <= load_data;
      end else if (deliver) begin
        full <= 1'b0;
      end

      if (deliver && (cnt != {CNTW{1'b1}})) begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/demux_stream_router.sv
// Purpose: 1-to-4 registered demux routing one valid/ready stream to four output slots by in_sel.
// Latency: 1 cycle from accept to out_valid/out_data; sustains 1 beat/cycle into a ready consumer.
// Backpressure: in_ready follows only the selected slot, so a stalled channel blocks only itself.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_sel input stream;
//        out_valid[k]/out_ready[k]/out_data[k*DW+:DW] per-channel streams; out_cnt[k*CNTW+:CNTW] delivered beats.
module demux_stream_router
  import demux_stream_router_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic [SELW-1:0]      in_sel,
  output logic [NOUT-1:0]      out_valid,
  input  logic [NOUT-1:0]      out_ready,
  output logic [NOUT*DW-1:0]   out_data,
  output logic [NOUT*CNTW-1:0] out_cnt
);

  logic [NOUT-1:0] sel_hot;
  logic [NOUT-1:0] can_load;
  logic [NOUT-1:0] load;

  assign sel_hot  = sel_onehot(in_sel);
  assign in_ready = |(can_load & sel_hot);
  // At most one bit of sel_hot is set, so at most one slot loads per cycle.
  assign load     = {NOUT{in_valid & in_ready}} & sel_hot;

  for (genvar k = 0; k < NOUT; k++) begin : g_slot
    demux_out_slot #(
      .DW  (DW),
      .CNTW(CNTW)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .load_data(in_data),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data (out_data[k*DW +: DW]),
      .out_cnt  (out_cnt[k*CNTW +: CNTW]),
      .can_load (can_load[k])
    );
  end

  // A valid beat must carry a known route.
  a_sel_known : assert property (@(posedge clk) disable iff (rst) in_valid |-> !$isunknown(in_sel));

endmodule

// File: tb/tb_demux_stream_router.sv
module tb_demux_stream_router;

  localparam int DW   = 8;
  localparam int CNTW = 8;
  localparam int NOUT = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic [1:0]           in_sel;
  logic [NOUT-1:0]      out_valid;
  logic [NOUT-1:0]      out_ready;
  logic [NOUT*DW-1:0]   out_data;
  logic [NOUT*CNTW-1:0] out_cnt;

  always #5 clk = ~clk;

  demux_stream_router #(.DW(DW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_cnt  (out_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: one queue of {channel, data}; each channel pops its oldest entry.
  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] dat;
  } sb_ent_t;

  sb_ent_t         sbq[$];
  logic [CNTW-1:0] exp_cnt  [NOUT];
  logic            pend_vld [NOUT];
  logic [DW-1:0]   pend_dat [NOUT];
  logic            hold_vld [NOUT];
  logic [DW-1:0]   hold_dat [NOUT];

  initial begin
    for (int k = 0; k < NOUT; k++) begin
      exp_cnt[k]  = '0;
      pend_vld[k] = 1'b0;
      pend_dat[k] = '0;
      hold_vld[k] = 1'b0;
      hold_dat[k] = '0;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      for (int k = 0; k < NOUT; k++) begin
        exp_cnt[k]  = '0;
        pend_vld[k] = 1'b0;
        hold_vld[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        check_eq($sformatf("cnt%0d", k), 64'(out_cnt[k*CNTW +: CNTW]), 64'(exp_cnt[k]));
        if (pend_vld[k]) begin
          check_eq($sformatf("lat_vld%0d", k), 64'(out_valid[k]), 64'd1);
          check_eq($sformatf("lat_dat%0d", k), 64'(out_data[k*DW +: DW]), 64'(pend_dat[k]));
          pend_vld[k] = 1'b0;
        end
        if (hold_vld[k]) begin
          check_eq($sformatf("hold_vld%0d", k), 64'(out_valid[k]), 64'd1);
          check_eq($sformatf("hold_dat%0d", k), 64'(out_data[k*DW +: DW]), 64'(hold_dat[k]));
          hold_vld[k] = 1'b0;
        end
        if (out_valid[k] && out_ready[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sbq.size(); i++) begin
            if (idx < 0 && sbq[i].ch == 2'(k)) idx = i;
          end
          if (idx < 0) begin
            check_eq($sformatf("sb_underflow%0d", k), 64'd1, 64'd0);
          end else begin
            check_eq($sformatf("sb_dat%0d", k), 64'(out_data[k*DW +: DW]), 64'(sbq[idx].dat));
            sbq.delete(idx);
          end
          if (exp_cnt[k] != {CNTW{1'b1}}) exp_cnt[k] = exp_cnt[k] + 1'b1;
        end else if (out_valid[k]) begin
          hold_vld[k] = 1'b1;
          hold_dat[k] = out_data[k*DW +: DW];
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{ch: in_sel, dat: in_data});
        pend_vld[in_sel] = 1'b1;
        pend_dat[in_sel] = in_data;
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic [DW-1:0] d);
    int n;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'b00;
    in_data   = 8'hEE;
    out_ready = 4'b1111;

    // 1. Reset with in_valid high: nothing loads.
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_vld", 64'(out_valid), 64'd0);
    check_eq("rst_cnt", 64'(out_cnt), 64'd0);
    check_eq("rst_dat", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_vld", 64'(out_valid), 64'd0);
    idle(1);

    // 2. Routing to each channel on consecutive cycles.
    send(2'b00, 8'hA0);
    send(2'b01, 8'hA1);
    send(2'b10, 8'hA2);
    send(2'b11, 8'hA3);
    idle(3);
    @(negedge clk);
    check_eq("route_cnt", 64'(out_cnt), 64'h01010101);
    idle(1);

    // 3. Backpressure on ch2 does not stall ch1.
    out_ready = 4'b1011;
    send(2'b10, 8'h55);
    in_valid = 1'b1;
    in_sel   = 2'b10;
    in_data  = 8'h66;
    @(negedge clk);
    check_eq("bp_rdy0", 64'(in_ready), 64'd0);
    check_eq("bp_dat2", 64'(out_data[2*DW +: DW]), 64'h55);
    idle(1);
    @(negedge clk);
    check_eq("bp_rdy1", 64'(in_ready), 64'd0);
    idle(1);
    send(2'b01, 8'h77);
    @(negedge clk);
    check_eq("bp_ch1", 64'(out_data[1*DW +: DW]), 64'h77);
    check_eq("bp_hold2", 64'(out_data[2*DW +: DW]), 64'h55);
    check_eq("bp_vld2", 64'(out_valid[2]), 64'd1);
    idle(1);
    out_ready = 4'b1111;
    idle(3);

    // 4. Pass-through: ch3 full, drain and refill in the same cycle.
    out_ready = 4'b0111;
    send(2'b11, 8'h11);
    idle(1);
    out_ready = 4'b1111;
    send(2'b11, 8'h22);
    @(negedge clk);
    check_eq("pt_vld3", 64'(out_valid[3]), 64'd1);
    check_eq("pt_dat3", 64'(out_data[3*DW +: DW]), 64'h22);
    check_eq("pt_cnt3", 64'(out_cnt[3*CNTW +: CNTW]), 64'd2);
    idle(3);

    // 5. Counter saturation on ch0.
    for (int i = 0; i < 300; i++) send(2'b00, 8'(i));
    idle(3);
    @(negedge clk);
    check_eq("sat_cnt0", 64'(out_cnt[0 +: CNTW]), 64'd255);
    idle(2);

    // 6. Mid-operation reset with all slots full.
    out_ready = 4'b0000;
    send(2'b00, 8'hC0);
    send(2'b01, 8'hC1);
    send(2'b10, 8'hC2);
    send(2'b11, 8'hC3);
    @(negedge clk);
    check_eq("full_vld", 64'(out_valid), 64'hF);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_vld", 64'(out_valid), 64'd0);
    check_eq("mrst_cnt", 64'(out_cnt), 64'd0);
    check_eq("mrst_dat", 64'(out_data), 64'd0);
    out_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mrst_nodeliver", 64'(out_valid), 64'd0);
    end

    // Drain whatever the scoreboard still expects.
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_drain", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
